arrow_pattern_gen: RTL and testbench

ARROW_PATTERN_GEN -- requirements
Module: arrow_pattern_gen

---
 rtl/arrow_pattern_gen.sv | 166 ++++++++++++++++
 tb/tb_arrow_pattern_gen.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/arrow_pattern_gen.sv
// Rhythm-game arrow pattern generator: beat timer, LFSR-driven arrows,
// difficulty ramp and game length tracking. Optional macro: ARROW_DOUBLE_EN.
//
// Ports:
//   CLOCK_50      in   system clock, all state on rising edge
//   reset         in   asynchronous active-high reset
//   start         in   start/restart request (ignored while playing)
//   pattern_valid out  one-cycle strobe qualifying pattern_out
//   pattern_out   out  [3:0] player A, [7:4] player B arrows
//                      (bit 3/7 up, 2/6 down, 1/5 left, 0/4 right)
//   game_over     out  high while the game is finished
//   level         out  current difficulty level (0..15)
//   beat_count    out  beats elapsed in the current game
//
// With ARROW_DOUBLE_EN defined, from level 4 on a second arrow may be
// added to each beat's pattern.
module arrow_pattern_gen #(
   parameter int unsigned BEAT_TICKS      = 25000000,
   parameter int unsigned MIN_BEAT_TICKS  = 6250000,
   parameter int unsigned SPEEDUP_STEP    = 1000000,
   parameter int unsigned BEATS_PER_LEVEL = 16,
   parameter int unsigned GAME_BEATS      = 240,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       start,
   output logic       pattern_valid,
   output logic [7:0] pattern_out,
   output logic       game_over,
   output logic [3:0] level,
   output logic [7:0] beat_count
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_OVER
   } state_t;

   state_t      state_q;
   logic [24:0] tick_q;
   logic [15:0] lfsr_q;
   logic [7:0]  lvl_cnt_q;
   logic [7:0]  beat_count_q;
   logic [3:0]  level_q;
   logic        pattern_valid_q;
   logic [7:0]  pattern_out_q;
   logic        game_over_q;

   logic [31:0] dec;
   logic [31:0] period_d;
   logic [31:0] period_m1;
   logic        beat;
   logic        rest;
   logic [3:0]  nib_d;
   logic [7:0]  pat_d;
   logic [15:0] lfsr_d;
   logic [7:0]  count_d;
   logic        lvl_wrap;
   logic        last_beat;

   function automatic logic [3:0] dir_bit(input logic [1:0] d);
      logic [3:0] r;
      unique case (d)
         2'd0:    r = 4'b0010;
         2'd1:    r = 4'b1000;
         2'd2:    r = 4'b0001;
         default: r = 4'b0100;
      endcase
      return r;
   endfunction

   // Beat period shrinks with level, floored; guarded so the
   // subtraction never wraps.
   always_comb begin
      dec      = 32'(level_q) * SPEEDUP_STEP;
      period_d = MIN_BEAT_TICKS;
      if (BEAT_TICKS > dec && (BEAT_TICKS - dec) > MIN_BEAT_TICKS) begin
         period_d = BEAT_TICKS - dec;
      end
      period_m1 = period_d - 32'd1;
   end

   assign beat = (state_q == S_PLAY) && ({7'd0, tick_q} == period_m1);

   // Arrow derivation from the LFSR value present at the beat.
   always_comb begin
      rest  = (lfsr_q[3:2] == 2'b11);
      nib_d = dir_bit(lfsr_q[1:0]);
`ifdef ARROW_DOUBLE_EN
      if (level_q >= 4'd4 && lfsr_q[4]) begin
         nib_d = nib_d | dir_bit(lfsr_q[6:5]);
      end
`endif
      pat_d = {nib_d, nib_d};
   end

   // Galois LFSR, right shift, taps 16'hB400.
   assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);

   assign count_d   = beat_count_q + 8'd1;
   assign lvl_wrap  = (({24'd0, lvl_cnt_q} + 32'd1) == BEATS_PER_LEVEL);
   assign last_beat = ({24'd0, count_d} == GAME_BEATS);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q         <= S_IDLE;
         tick_q          <= '0;
         lfsr_q          <= LFSR_SEED;
         lvl_cnt_q       <= '0;
         beat_count_q    <= '0;
         level_q         <= '0;
         pattern_valid_q <= 1'b0;
         pattern_out_q   <= '0;
         game_over_q     <= 1'b0;
      end else begin
         pattern_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_OVER: begin
               if (start) begin
                  state_q      <= S_PLAY;
                  tick_q       <= '0;
                  lvl_cnt_q    <= '0;
                  beat_count_q <= '0;
                  level_q      <= '0;
                  game_over_q  <= 1'b0;
               end
            end
            S_PLAY: begin
               if (beat) begin
                  tick_q       <= '0;
                  lfsr_q       <= lfsr_d;
                  beat_count_q <= count_d;
                  if (!rest) begin
                     pattern_valid_q <= 1'b1;
                     pattern_out_q   <= pat_d;
                  end
                  if (lvl_wrap) begin
                     lvl_cnt_q <= '0;
                     if (level_q != 4'd15) begin
                        level_q <= level_q + 4'd1;
                     end
                  end else begin
                     lvl_cnt_q <= lvl_cnt_q + 8'd1;
                  end
                  if (last_beat) begin
                     state_q     <= S_OVER;
                     game_over_q <= 1'b1;
                  end
               end else begin
                  tick_q <= tick_q + 25'd1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pattern_valid = pattern_valid_q;
   assign pattern_out   = pattern_out_q;
   assign game_over     = game_over_q;
   assign level         = level_q;
   assign beat_count    = beat_count_q;

endmodule

// File: tb/tb_arrow_pattern_gen.sv
// Scoreboard bench for arrow_pattern_gen with short beat timing.
// Expected strobes are queued at start; a monitor pops on each strobe.
module tb_arrow_pattern_gen;

   localparam int BT  = 8;
   localparam int MB  = 4;
   localparam int SS  = 1;
   localparam int BPL = 4;
   localparam int GB  = 20;

   logic       CLOCK_50 = 1'b0;
   logic       reset;
   logic       start;
   logic       pattern_valid;
   logic [7:0] pattern_out;
   logic       game_over;
   logic [3:0] level;
   logic [7:0] beat_count;

   arrow_pattern_gen #(
      .BEAT_TICKS     (BT),
      .MIN_BEAT_TICKS (MB),
      .SPEEDUP_STEP   (SS),
      .BEATS_PER_LEVEL(BPL),
      .GAME_BEATS     (GB),
      .LFSR_SEED      (16'hACE1)
   ) dut (
      .CLOCK_50     (CLOCK_50),
      .reset        (reset),
      .start        (start),
      .pattern_valid(pattern_valid),
      .pattern_out  (pattern_out),
      .game_over    (game_over),
      .level        (level),
      .beat_count   (beat_count)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int cyc = 0;
   always @(posedge CLOCK_50) cyc <= cyc + 1;

   typedef struct {
      int         t;
      logic [7:0] pat;
      logic       go;
   } exp_t;

   exp_t q[$];
   int n_chk  = 0;
   int n_fail = 0;

   logic [15:0] m_lfsr;
   logic [7:0]  m_last;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Direction table: 0 left, 1 up, 2 right, 3 down.
   function automatic logic [3:0] arrow(input logic [1:0] d);
      logic [3:0] tbl [4];
      tbl[0] = 4'b0010;
      tbl[1] = 4'b1000;
      tbl[2] = 4'b0001;
      tbl[3] = 4'b0100;
      return tbl[d];
   endfunction

   function automatic int beat_len(input int beats_done);
      int lv;
      int p;
      lv = beats_done / BPL;
      if (lv > 15) lv = 15;
      p = BT - lv * SS;
      if (p < MB) p = MB;
      return p;
   endfunction

   // Queue the strobes of the first nbeats beats of a game entered at
   // cycle 'entry'; return time of last beat's strobe and the next one.
   task automatic plan_game(input int entry, input int nbeats,
                            output int t_last, output int t_next);
      int t;
      logic [3:0] nib;
      exp_t e;
      t = entry;
      for (int k = 1; k <= nbeats; k++) begin
         t += beat_len(k - 1);
         nib = arrow(m_lfsr[1:0]);
`ifdef ARROW_DOUBLE_EN
         if (((k - 1) / BPL) >= 4 && m_lfsr[4]) nib = nib | arrow(m_lfsr[6:5]);
`endif
         if (m_lfsr[3:2] != 2'b11) begin
            e.t   = t;
            e.pat = {nib, nib};
            e.go  = (k == GB);
            q.push_back(e);
            m_last = {nib, nib};
         end
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end
      t_last = t;
      t_next = t + beat_len(nbeats);
   endtask

   // Monitor: every strobe must match the head of the queue.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLOCK_50);
         if (pattern_valid) begin
            if (q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_strobe: got pattern %0h at cyc %0d expected none",
                        pattern_out, cyc);
            end else begin
               e = q.pop_front();
               chk("strobe_time", cyc, e.t);
               chk("strobe_pattern", {24'd0, pattern_out}, {24'd0, e.pat});
               chk("strobe_game_over", {31'd0, game_over}, {31'd0, e.go});
            end
         end
      end
   end

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge CLOCK_50);
   endtask

   task automatic pulse_start(output int entry);
      @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      entry = cyc;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, {31'd0, pattern_valid}, 32'd0);
      chk({tag, "_pattern"}, {24'd0, pattern_out}, 32'd0);
      chk({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
      chk({tag, "_level"}, {28'd0, level}, 32'd0);
      chk({tag, "_beat_count"}, {24'd0, beat_count}, 32'd0);
   endtask

   initial begin
      int entry;
      int t_last;
      int t_next;
      int lim;
      reset  = 1'b1;
      start  = 1'b0;
      m_lfsr = 16'hACE1;
      m_last = 8'h00;
      repeat (3) @(negedge CLOCK_50);
      chk_zero("reset");
      reset = 1'b0;
      wait_until(cyc + 20);

      // Game 1: full game with an ignored mid-game start.
      pulse_start(entry);
      plan_game(entry, GB, t_last, t_next);
      wait_until(entry + 8);
      chk("first_pattern_88", {24'd0, pattern_out}, 32'h88);
      wait_until(entry + 16);
      chk("second_pattern_22", {24'd0, pattern_out}, 32'h22);
      wait_until(entry + 20);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      wait_until(entry + 33);
      chk("level_after_4", {28'd0, level}, 32'd1);
      chk("count_after_4", {24'd0, beat_count}, 32'd4);
      lim = cyc + 300;
      while (!game_over && cyc < lim) @(negedge CLOCK_50);
      chk("game_over_time", cyc, t_last);
      chk("final_beat_count", {24'd0, beat_count}, GB);
      chk("final_level", {28'd0, level}, 32'd5);
      wait_until(cyc + 100);
      chk("over_beat_count_held", {24'd0, beat_count}, GB);
      chk("over_game_over_held", {31'd0, game_over}, 32'd1);
      chk("over_pattern_held", {24'd0, pattern_out}, {24'd0, m_last});

      // Game 2: restart from OVER, then reset 3 cycles before beat 4.
      pulse_start(entry);
      chk("restart_game_over", {31'd0, game_over}, 32'd0);
      chk("restart_beat_count", {24'd0, beat_count}, 32'd0);
      chk("restart_level", {28'd0, level}, 32'd0);
      plan_game(entry, 3, t_last, t_next);
      wait_until(t_next - 4);
      reset = 1'b1;
      #1;
      chk_zero("async_reset");
      m_lfsr = 16'hACE1;
      repeat (2) @(negedge CLOCK_50);
      reset = 1'b0;
      wait_until(cyc + 40);
      chk("idle_queue_drained", q.size(), 32'd0);

      // Game 3: LFSR must restart from its seed.
      pulse_start(entry);
      plan_game(entry, 2, t_last, t_next);
      wait_until(entry + 8);
      chk("reseeded_pattern_88", {24'd0, pattern_out}, 32'h88);
      wait_until(t_last + 2);
      chk("final_queue_drained", q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
